seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the team's 7-segment display encoders. The block watches a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot digit selects). It debounces each digit's pattern and decodes it back to a hex nibble, then delivers one complete multi-digit frame at a time over a valid/ready handshake. It sits between external display-scan pins, or an internal display driver under test, and any consumer that needs the displayed value in binary.

## Interface
- DIGITS, default 4: number of multiplexed digits (1..8).
- STABLE, default 4: consecutive identical samples required before a digit is captured (2..255).
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active-low, bit 6 = g … bit 0 = a; asynchronous to clk.
- dig  in  DIGITS  digit selects, active-high, one-hot when valid; asynchronous to clk.
- out_val  out  4*DIGITS  decoded nibbles; digit i in out_val[4*i+3:4*i].
- out_blank  out  DIGITS  digit i was blank (seg = 7'b1111111).
- out_err  out  DIGITS  digit i held an undecodable pattern.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: at least one complete frame was dropped.

## Operation
- Input path: {dig, seg} passes through a 2-flop synchronizer (s1, s2); all logic uses s2.
- Stability counter cnt, width $clog2(STABLE+1):
  - If s2 equals the previous s2 and dig is exactly one-hot, cnt increments, saturating at STABLE. Otherwise cnt = 1 when dig is one-hot, else 0.
  - Capture strobe fires on the single edge where cnt goes from STABLE-1 to STABLE. It never repeats while the pattern is held.
- Decode table, inverse of the team encoder constants:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
  - 1111111 → nibble 0, blank=1.
  - Any other pattern → nibble 0, err=1.
- Capture: writes nibble/blank/err into the collect registers of the selected digit and sets that digit's bit in got_mask. Only the first capture of a digit per frame is kept; later captures of an already-got digit are ignored.
- Frame FSM:
  - COLLECT: entered at reset. When got_mask is all ones, next edge snapshots the collect registers into the out_* registers and clears got_mask.
  - If out_valid=1 and no handshake happens in that same cycle, the snapshot is dropped instead, overrun←1, and got_mask is still cleared.
  - The snapshot edge sets out_valid=1.
- Handshake: out_valid && out_ready at an edge clears out_valid. A snapshot on that same edge is accepted (no overrun) and reasserts out_valid with the new data.
- out_* data is stable while out_valid=1 and not yet accepted.
- overrun clears on the next completed handshake unless a drop occurs on the same edge; set wins.

## Timing
- Reset (async assert, sync release): s1, s2, cnt, got_mask, collect regs, out_val, out_blank, out_err, out_valid and overrun all 0.
- Reset mid-frame discards the partial frame and any pending output.
- Input stable before edge k: s2 holds it after edge k+1, and capture occurs at edge k+STABLE.
- The last digit captured at edge c gives a snapshot and out_valid=1 after edge c+1.
- End-to-end: final digit held from before edge k gives out_valid after edge k+STABLE+1.
- A digit window shorter than STABLE+1 cycles (the synchronizer-plus-compare margin) may be missed.
- No combinational path from out_ready to out_valid.
- dig all-zero or multi-hot: no capture, cnt 0/1 per the rules above.
- Throughput: at most one frame per DIGITS×(STABLE+1) cycles.

## Test plan
- Basic decode (DIGITS=4, STABLE=4, out_ready=1): drive dig=0001/seg=1111001, 0010/0100100, 0100/0001000, 1000/0001110, each held 6 cycles → one out_valid pulse, out_val=16'hFA21, out_blank=0, out_err=0, first out_valid exactly 6 cycles after the last digit's pattern is applied.
- Glitch rejection: hold digit 0 pattern 0110000 for 3 cycles, then 0000000 for 6 → digit 0 captures 8, not 3. Single-cycle dig=0011 pulses produce no capture.
- Blank/error: digit 1 = 1111111, digit 2 = 0111111 → out_blank=4'b0010, out_err=4'b0100, corresponding nibbles 0.
- Backpressure/overrun: out_ready=0 across two full frames → out_val keeps frame 1, overrun=1. Raise out_ready for 1 cycle → out_valid drops, overrun clears. Then a handshake coinciding with a snapshot edge → out_valid stays 1 with new data, overrun stays 0.
- Repeat-digit: scan digit 0 twice before digits 1-3, with a different pattern second time → frame holds the first pattern.
- Async reset asserted mid-frame with 2 digits captured → all outputs 0 immediately. After release, a full 4-digit scan is needed before out_valid=1.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, debounces and decodes each digit,
// and hands complete multi-digit frames to a consumer over valid/ready.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   out_val,
  output logic [DIGITS-1:0]     out_blank,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned BW = DIGITS + 7;
  localparam int unsigned CW = $clog2(STABLE + 1);

  typedef enum logic {COLLECT, SNAP} state_t;

  state_t              state, state_next;
  logic [BW-1:0]       s1, s2;
  logic [CW-1:0]       cnt, cnt_next;
  logic [DIGITS-1:0]   s1_dig, s2_dig;
  logic [6:0]          s2_seg;
  logic                s1_onehot;
  logic                cap;
  logic [DIGITS-1:0]   cap_sel, got_mask, got_base, got_next, wr;
  logic [5:0]          dec;
  logic                snap, hs, drop;
  logic [4*DIGITS-1:0] col_val;
  logic [DIGITS-1:0]   col_blank, col_err;

  // Returns {err, blank, nibble} for one active-low segment pattern.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b10_0000;
    case (p)
      7'b1000000: r = 6'h00;
      7'b1111001: r = 6'h01;
      7'b0100100: r = 6'h02;
      7'b0110000: r = 6'h03;
      7'b0011001: r = 6'h04;
      7'b0010010: r = 6'h05;
      7'b0000010: r = 6'h06;
      7'b1111000: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0010000: r = 6'h09;
      7'b0001000: r = 6'h0A;
      7'b0000011: r = 6'h0B;
      7'b1000110: r = 6'h0C;
      7'b0100001: r = 6'h0D;
      7'b0000110: r = 6'h0E;
      7'b0001110: r = 6'h0F;
      7'b1111111: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  assign s1_dig    = s1[BW-1:7];
  assign s2_dig    = s2[BW-1:7];
  assign s2_seg    = s2[6:0];
  assign s1_onehot = (s1_dig != '0) && ((s1_dig & (s1_dig - DIGITS'(1))) == '0);
  assign dec       = decode(s2_seg);

  // s1 is the value s2 takes next, so comparing it to s2 tracks "s2 unchanged".
  always_comb begin
    cnt_next = '0;
    if (s1_onehot) begin
      if (s1 == s2) cnt_next = (cnt == CW'(STABLE)) ? cnt : cnt + CW'(1);
      else          cnt_next = CW'(1);
    end
    cap     = (cnt == CW'(STABLE - 1)) && (cnt_next == CW'(STABLE));
    cap_sel = cap ? s2_dig : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
    end else begin
      s1  <= {dig, seg};
      s2  <= s1;
      cnt <= cnt_next;
    end
  end

  // Frame FSM: SNAP is the single edge that moves a full frame to the outputs.
  always_comb begin
    state_next = state;
    snap       = 1'b0;
    got_base   = got_mask;
    case (state)
      COLLECT: if (&(got_mask | cap_sel)) state_next = SNAP;
      SNAP: begin
        snap       = 1'b1;
        got_base   = '0;
        state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
    wr       = cap_sel & ~got_base;
    got_next = got_base | cap_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      got_mask <= '0;
    end else begin
      state    <= state_next;
      got_mask <= got_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_val   <= '0;
      col_blank <= '0;
      col_err   <= '0;
    end else begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (wr[i]) begin
          col_val[4*i +: 4] <= dec[3:0];
          col_blank[i]      <= dec[4];
          col_err[i]        <= dec[5];
        end
      end
    end
  end

  assign hs   = out_valid && out_ready;
  assign drop = snap && out_valid && !out_ready;

  // A snapshot meeting a handshake replaces the accepted frame; otherwise it is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val   <= '0;
      out_blank <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (snap && !drop) begin
        out_val   <= col_val;
        out_blank <= col_blank;
        out_err   <= col_err;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (drop)    overrun <= 1'b1;
      else if (hs) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scenarios plus randomized digit windows checked against a frame-level model.
module tb_seg7_scan_decoder;

  localparam int unsigned D = 4;
  localparam int unsigned S = 4;
  localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg;
  logic [D-1:0]   dig;
  logic [4*D-1:0] out_val;
  logic [D-1:0]   out_blank, out_err;
  logic           out_valid, out_ready, overrun;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit rdy_rand = 1'b0;
  int low_run = 0;
  logic [63:0] exp_q [$];

  logic [3:0]   m_val [D];
  logic [D-1:0] m_blank, m_err, m_got;

  seg7_scan_decoder #(.DIGITS(D), .STABLE(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dig(dig),
    .out_val(out_val), .out_blank(out_blank), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 6'b01_0000;
    for (int v = 0; v < 16; v++) if (ENC[v] == s) return {2'b00, 4'(v)};
    return 6'b10_0000;
  endfunction

  function automatic logic [63:0] pack_dut();
    return 64'({out_val, out_blank, out_err});
  endfunction

  // A one-hot window held at least S cycles yields a capture unless the digit is already in.
  function automatic void model_window(input logic [D-1:0] d, input logic [6:0] s, input int n);
    int idx;
    logic [5:0] r;
    logic [4*D-1:0] v;
    if (n < int'(S) || $countones(d) != 1) return;
    idx = 0;
    for (int i = 0; i < int'(D); i++) if (d[i]) idx = i;
    if (m_got[idx]) return;
    r = ref_decode(s);
    m_val[idx] = r[3:0];
    m_blank[idx] = r[4];
    m_err[idx] = r[5];
    m_got[idx] = 1'b1;
    if (m_got == '1) begin
      for (int i = 0; i < int'(D); i++) v[4*i +: 4] = m_val[i];
      exp_q.push_back(64'({v, m_blank, m_err}));
      m_got = '0;
    end
  endfunction

  task automatic tick(input logic [D-1:0] d, input logic [6:0] s);
    @(negedge clk);
    dig = d;
    seg = s;
    if (rdy_rand) begin
      out_ready = (low_run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      low_run = out_ready ? 0 : low_run + 1;
    end
    #1;
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("frame_extra", 64'(1), 64'(0));
      else check("frame", pack_dut(), exp_q.pop_front());
    end
  endtask

  task automatic hold(input logic [D-1:0] d, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) tick(d, s);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    hold(4'b0001, p0, 6);
    hold(4'b0010, p1, 6);
    hold(4'b0100, p2, 6);
    hold(4'b1000, p3, 6);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick('0, 7'h7F);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick('0, 7'h7F);
  endtask

  initial begin
    int first, pulses;
    bit seen;
    logic [4*D-1:0] v;
    logic [D-1:0] b, e, d;
    logic [6:0] s;
    int n, r;

    reset = 1'b1; dig = '0; seg = 7'h7F; out_ready = 1'b1;
    m_got = '0; m_blank = '0; m_err = '0;
    for (int i = 0; i < int'(D); i++) m_val[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_val", 64'(out_val), 64'(0));
    check("rst_blank", 64'(out_blank), 64'(0));
    check("rst_err", 64'(out_err), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Basic decode and end-to-end latency
    hold(4'b0001, 7'h79, 6);
    hold(4'b0010, 7'h24, 6);
    hold(4'b0100, 7'h08, 6);
    first = -1; pulses = 0; v = '0; b = '1; e = '1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) tick(4'b1000, 7'h0E); else tick('0, 7'h7F);
      if (out_valid) begin
        pulses++;
        if (first < 0) begin first = i; v = out_val; b = out_blank; e = out_err; end
      end
    end
    check("basic_latency", 64'(first), 64'(6));
    check("basic_pulses", 64'(pulses), 64'(1));
    check("basic_val", 64'(v), 64'(16'hFA21));
    check("basic_blank", 64'(b), 64'(0));
    check("basic_err", 64'(e), 64'(0));

    // Glitch rejection: multi-hot pulses and a too-short pattern
    tick(4'b0011, 7'h79); tick('0, 7'h7F);
    tick(4'b0011, 7'h24); tick('0, 7'h7F);
    hold(4'b0001, 7'h30, 3);
    hold(4'b0001, 7'h00, 6);
    hold(4'b0010, 7'h79, 6);
    hold(4'b0100, 7'h24, 6);
    hold(4'b1000, 7'h30, 6);
    wait_valid("glitch", 20);
    check("glitch_val", 64'(out_val), 64'(16'h3218));
    consume();

    // Blank and undecodable digits
    scan(7'h40, 7'h7F, 7'h3F, 7'h79);
    wait_valid("blank", 20);
    check("blank_val", 64'(out_val), 64'(16'h1000));
    check("blank_mask", 64'(out_blank), 64'(4'b0010));
    check("err_mask", 64'(out_err), 64'(4'b0100));
    consume();

    // Backpressure: second frame dropped, first held
    out_ready = 1'b0;
    scan(7'h12, 7'h02, 7'h78, 7'h10);
    hold('0, 7'h7F, 2);
    check("bp_valid_a", 64'(out_valid), 64'(1));
    check("bp_val_a", 64'(out_val), 64'(16'h9765));
    check("bp_overrun_a", 64'(overrun), 64'(0));
    scan(7'h79, 7'h24, 7'h30, 7'h19);
    hold('0, 7'h7F, 2);
    check("bp_overrun_b", 64'(overrun), 64'(1));
    check("bp_val_b", 64'(out_val), 64'(16'h9765));
    check("bp_valid_b", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick('0, 7'h7F);
    out_ready = 1'b0;
    check("bp_accept_valid", 64'(out_valid), 64'(0));
    check("bp_accept_overrun", 64'(overrun), 64'(0));

    // Handshake on the same edge as a snapshot
    scan(7'h08, 7'h03, 7'h46, 7'h21);
    hold('0, 7'h7F, 2);
    check("co_val_c", 64'(out_val), 64'(16'hDCBA));
    hold(4'b0001, 7'h06, 6);
    hold(4'b0010, 7'h0E, 6);
    hold(4'b0100, 7'h40, 6);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) tick(4'b1000, 7'h79); else tick('0, 7'h7F);
      if (i == 5) out_ready = 1'b1;
    end
    out_ready = 1'b0;
    check("co_valid", 64'(out_valid), 64'(1));
    check("co_val_d", 64'(out_val), 64'(16'h10FE));
    check("co_overrun", 64'(overrun), 64'(0));
    consume();

    // Repeated digit keeps its first capture
    hold(4'b0001, 7'h79, 6);
    hold(4'b0001, 7'h24, 6);
    hold(4'b0010, 7'h30, 6);
    hold(4'b0100, 7'h19, 6);
    hold(4'b1000, 7'h12, 6);
    wait_valid("repeat", 20);
    check("repeat_val", 64'(out_val), 64'(16'h5431));
    consume();

    // Async reset mid-frame with a pending frame and overrun
    out_ready = 1'b0;
    scan(7'h00, 7'h00, 7'h00, 7'h00);
    scan(7'h00, 7'h00, 7'h00, 7'h00);
    hold('0, 7'h7F, 2);
    check("pre_rst_overrun", 64'(overrun), 64'(1));
    hold(4'b0001, 7'h79, 6);
    hold(4'b0010, 7'h24, 6);
    @(negedge clk);
    #2 reset = 1'b1; dig = '0; seg = 7'h7F;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_val", 64'(out_val), 64'(0));
    check("mid_rst_overrun", 64'(overrun), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i < 6) tick(4'b0100, 7'h79);
      else if (i < 12) tick(4'b1000, 7'h24);
      else tick('0, 7'h7F);
      if (out_valid) seen = 1'b1;
    end
    check("rst_partial", 64'(seen), 64'(0));
    hold(4'b0001, 7'h40, 6);
    hold(4'b0010, 7'h40, 6);
    wait_valid("post_rst", 20);
    check("post_rst_val", 64'(out_val), 64'(16'h2100));
    consume();

    // Randomized windows against the frame model
    mon_en = 1'b1;
    rdy_rand = 1'b1;
    for (int w = 0; w < 90; w++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) d = D'(1) << $urandom_range(0, D - 1);
      else if (r == 8) d = '0;
      else d = D'(3) << $urandom_range(0, D - 2);
      r = int'($urandom_range(0, 9));
      if (r < 6) s = ENC[$urandom_range(0, 15)];
      else if (r < 8) s = 7'h7F;
      else s = 7'($urandom);
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, S - 1));
      else n = int'($urandom_range(S + 1, S + 4));
      model_window(d, s, n);
      hold(d, s, n);
      tick('0, 7'h7F);
    end
    hold('0, 7'h7F, 40);
    check("rand_drain", 64'(exp_q.size()), 64'(0));
    check("rand_overrun", 64'(overrun), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
